// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receive FSM state encoding, byte width and the
// default slave address used by both the front end and the slave controller.
package i2c_pkg;

    localparam int BYTE_BITS = 8;

    localparam logic [6:0] I2C_SLAVE_ADDR = 7'b1111000;

    typedef logic [1:0] i2c_state_t;

    localparam i2c_state_t IDLE     = 2'd0;
    localparam i2c_state_t RX       = 2'd1;
    localparam i2c_state_t WAIT_ACK = 2'd2;
    localparam i2c_state_t ACK      = 2'd3;

endpackage

// File: rtl/i2c_sync_edge.sv
// Pin synchronizer with edge detect: a SYNC_STAGES-deep flop chain brings the
// raw pin into the clk domain, one more flop holds the previous synchronized
// value, and rise/fall are the combinational compare of the two.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic synced,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the pin through the chain; idle bus is high, so reset to ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign synced = chain[SYNC_STAGES-1];
    assign rise   = synced & ~prev;
    assign fall   = ~synced & prev;

endmodule

// File: rtl/i2c_rx_front_end.sv
// I2C receive front end: synchronizes scl/sda, detects START/STOP and scl
// edges, deserializes bytes MSB-first, decodes the address byte and frames
// the ACK slot. Observes the bus only; sda is never driven from here.
module i2c_rx_front_end
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       start_found,
    output logic       stop_found,
    output logic       rising_scl,
    output logic       falling_scl,
    output logic       byte_received,
    output logic [7:0] rx_data,
    output logic       addr_byte,
    output logic       address_match,
    output logic       rw_mode,
    output logic       ack_window,
    output logic       ack_sampled
);

    logic scl_s, scl_p, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    // sda's previous value is already folded into its rise/fall pulses.
    logic sda_p_unused;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (clk),
        .rst    (rst),
        .pin    (scl),
        .synced (scl_s),
        .prev   (scl_p),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (clk),
        .rst    (rst),
        .pin    (sda_in),
        .synced (sda_s),
        .prev   (sda_p_unused),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // sda may only signal a condition while scl was high in both the current
    // and previous synchronized cycle; a simultaneous scl edge suppresses it.
    logic scl_stable_hi, start_c, stop_c;
    assign scl_stable_hi = scl_s & scl_p;
    assign start_c       = scl_stable_hi & sda_fall;
    assign stop_c        = scl_stable_hi & sda_rise;

    i2c_state_t           state;
    logic [3:0]           bit_cnt;
    logic                 first;
    logic [BYTE_BITS-1:0] shift;
    logic [BYTE_BITS-1:0] shift_nxt;
    logic                 last_bit;

    assign shift_nxt = {shift[BYTE_BITS-2:0], sda_s};
    assign last_bit  = (bit_cnt == 4'(BYTE_BITS - 1));

    // Receive FSM plus registered pulse outputs; START/STOP override any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            first         <= 1'b0;
            shift         <= '0;
            start_found   <= 1'b0;
            stop_found    <= 1'b0;
            rising_scl    <= 1'b0;
            falling_scl   <= 1'b0;
            byte_received <= 1'b0;
            addr_byte     <= 1'b0;
            rx_data       <= 8'h00;
            address_match <= 1'b0;
            rw_mode       <= 1'b0;
            ack_window    <= 1'b0;
            ack_sampled   <= 1'b1;
        end else begin
            start_found   <= start_c;
            stop_found    <= stop_c;
            rising_scl    <= scl_rise;
            falling_scl   <= scl_fall;
            byte_received <= 1'b0;
            addr_byte     <= 1'b0;
            if (start_c) begin
                state         <= RX;
                bit_cnt       <= '0;
                first         <= 1'b1;
                ack_window    <= 1'b0;
                address_match <= 1'b0;
            end else if (stop_c) begin
                state         <= IDLE;
                ack_window    <= 1'b0;
                address_match <= 1'b0;
            end else begin
                case (state)
                    RX: begin
                        if (scl_rise) begin
                            shift   <= shift_nxt;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit) begin
                                rx_data       <= shift_nxt;
                                byte_received <= 1'b1;
                                addr_byte     <= first;
                                if (first) begin
                                    address_match <= (shift_nxt[7:1] == SLAVE_ADDR);
                                    rw_mode       <= shift_nxt[0];
                                    first         <= 1'b0;
                                end
                                state <= WAIT_ACK;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (scl_fall) begin
                            ack_window <= 1'b1;
                            state      <= ACK;
                        end
                    end
                    ACK: begin
                        // Entered on a fall, so the next fall closes the 9th bit.
                        if (scl_rise) ack_sampled <= sda_s;
                        if (scl_fall) begin
                            ack_window <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= address_match ? RX : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
